// File: rtl/done_led_pkg.sv
// Shared types and helpers for the DONE LED pattern generator.
package done_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  typedef enum logic {
    RAMP_UP   = 1'b0,
    RAMP_DOWN = 1'b1
  } breathe_state_t;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/done_led_tick.sv
// Free-running prescaler: one-cycle tick strobe every DIV clocks.
module done_led_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rstN,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == LAST);
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/done_led_pattern.sv
// DONE LED pattern generator: off / on / blink / breathe, drives USRDONETS.
//   state     | meaning
//   RAMP_UP   | breathe duty rising one step per tick toward all-ones
//   RAMP_DOWN | breathe duty falling one step per tick toward zero
module done_led_pattern
  import done_led_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int BLINK_TICKS = 250,
  parameter int PWM_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [1:0]           mode,
  output logic                 done_ts,
  output logic [PWM_WIDTH-1:0] duty,
  output logic                 tick
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int TCW = $clog2(BLINK_TICKS + 1);
  localparam logic [TCW-1:0]       TC_LAST  = TCW'(BLINK_TICKS - 1);
  localparam logic [PWM_WIDTH-1:0] DUTY_TOP = {{(PWM_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [PWM_WIDTH-1:0] DUTY_ONE = PWM_WIDTH'(1);

  logic                 w_tick;
  logic                 w_restart;
  mode_t                r_mode_q;
  logic [PWM_WIDTH-1:0] r_pwm_cnt;
  logic [TCW-1:0]       r_tick_cnt, w_tick_cnt_nxt;
  logic                 r_blink_ph, w_blink_ph_nxt;
  breathe_state_t       r_state, w_state_nxt;
  logic [PWM_WIDTH-1:0] r_duty, w_duty_nxt;
  logic                 r_done_ts, w_done_ts_nxt;

  done_led_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rstN (rstN),
    .tick (w_tick)
  );

  assign w_restart = (mode_t'(mode) != r_mode_q);

  always_comb begin
    w_tick_cnt_nxt = r_tick_cnt;
    w_blink_ph_nxt = r_blink_ph;
    w_state_nxt    = r_state;
    w_duty_nxt     = r_duty;
    w_done_ts_nxt  = 1'b0;

    case (r_mode_q)
      MODE_ON:      w_done_ts_nxt = 1'b1;
      MODE_BLINK:   w_done_ts_nxt = r_blink_ph;
      MODE_BREATHE: w_done_ts_nxt = (r_pwm_cnt < r_duty);
      default:      w_done_ts_nxt = 1'b0;
    endcase

    // A mode change restarts the pattern and swallows a coincident tick.
    if (w_restart) begin
      w_tick_cnt_nxt = '0;
      w_blink_ph_nxt = 1'b0;
      w_state_nxt    = RAMP_UP;
      w_duty_nxt     = '0;
    end else if (r_mode_q == MODE_BLINK) begin
      if (w_tick) begin
        if (r_tick_cnt == TC_LAST) begin
          w_tick_cnt_nxt = '0;
          w_blink_ph_nxt = ~r_blink_ph;
        end else begin
          w_tick_cnt_nxt = r_tick_cnt + TCW'(1);
        end
      end
    end else if (r_mode_q == MODE_BREATHE) begin
      if (w_tick) begin
        case (r_state)
          RAMP_UP: begin
            w_duty_nxt = r_duty + DUTY_ONE;
            if (r_duty == DUTY_TOP) w_state_nxt = RAMP_DOWN;
          end
          default: begin
            w_duty_nxt = r_duty - DUTY_ONE;
            if (r_duty == DUTY_ONE) w_state_nxt = RAMP_UP;
          end
        endcase
      end
    end else begin
      w_duty_nxt  = '0;
      w_state_nxt = RAMP_UP;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_mode_q   <= MODE_OFF;
      r_pwm_cnt  <= '0;
      r_tick_cnt <= '0;
      r_blink_ph <= 1'b0;
      r_state    <= RAMP_UP;
      r_duty     <= '0;
      r_done_ts  <= 1'b0;
    end else begin
      r_mode_q   <= mode_t'(mode);
      r_pwm_cnt  <= r_pwm_cnt + DUTY_ONE;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_blink_ph <= w_blink_ph_nxt;
      r_state    <= w_state_nxt;
      r_duty     <= w_duty_nxt;
      r_done_ts  <= w_done_ts_nxt;
    end
  end

  assign done_ts = r_done_ts;
  assign duty    = r_duty;
  assign tick    = w_tick;

endmodule

// File: tb/tb_done_led_pattern.sv
// Self-checking bench for done_led_pattern against a tick-count reference model.
module tb_done_led_pattern;

  localparam int DIV  = 10;
  localparam int BT   = 3;
  localparam int DMAX = 15;
  localparam int PER  = 2 * DMAX;

  logic       clk  = 1'b0;
  logic       rstN = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       done_ts;
  logic [3:0] duty;
  logic       tick;

  int checks   = 0;
  int failures = 0;

  // Reference model: edges since release, registered mode, ticks since restart.
  int cyc;
  int m_mode_q;
  int m_nt;
  bit m_done;

  done_led_pattern #(
    .CLK_HZ(1000), .TICK_HZ(100), .BLINK_TICKS(BT), .PWM_WIDTH(4)
  ) dut (
    .clk(clk), .rstN(rstN), .mode(mode), .done_ts(done_ts), .duty(duty), .tick(tick)
  );

  always #5 clk = ~clk;

  function automatic int tri_duty(input int n);
    int p;
    p = n % PER;
    return (p <= DMAX) ? p : PER - p;
  endfunction

  function automatic int exp_duty();
    return (m_mode_q == 3) ? tri_duty(m_nt) : 0;
  endfunction

  function automatic bit exp_tick();
    return (cyc > 0) && (cyc % DIV == 0);
  endfunction

  task automatic model_reset();
    cyc = 0; m_mode_q = 0; m_nt = 0; m_done = 1'b0;
  endtask

  task automatic step();
    bit t;
    int pwm;
    bit ph;
    @(posedge clk);
    t   = exp_tick();
    pwm = cyc % 16;
    ph  = ((m_nt / BT) % 2) == 1;
    case (m_mode_q)
      0:       m_done = 1'b0;
      1:       m_done = 1'b1;
      2:       m_done = ph;
      default: m_done = (pwm < exp_duty());
    endcase
    if (int'(mode) != m_mode_q) m_nt = 0;
    else if (t && m_mode_q >= 2) m_nt++;
    m_mode_q = int'(mode);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    int first;
    rstN = 1'b0; mode = 2'd0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_ts !== 1'b0 || duty !== 4'd0 || tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: done_ts=%b duty=%0d tick=%b want 0/0/0", done_ts, duty, tick);
    end
    @(negedge clk); rstN = 1'b1;
    model_reset();
    first = -1;
    for (int i = 0; i < 35; i++) begin
      step();
      if (tick === 1'b1 && first < 0) first = cyc;
      checks++;
      if (tick !== exp_tick() || done_ts !== 1'b0 || duty !== 4'd0) begin
        failures++;
        $display("FAIL reset_tick cyc=%0d: tick=%b done_ts=%b duty=%0d want tick=%b 0 0", cyc, tick, done_ts, duty, exp_tick());
      end
    end
    checks++;
    if (first != 10) begin
      failures++;
      $display("FAIL first_tick: got cycle %0d want 10", first);
    end
  endtask

  task automatic test_off_on();
    mode = 2'd1;
    step();
    checks++;
    if (done_ts !== 1'b0) begin failures++; $display("FAIL on_lat1: done_ts=%b want 0", done_ts); end
    step();
    checks++;
    if (done_ts !== 1'b1) begin failures++; $display("FAIL on_lat2: done_ts=%b want 1", done_ts); end
    repeat (5) step();
    mode = 2'd0;
    step();
    checks++;
    if (done_ts !== 1'b1) begin failures++; $display("FAIL off_lat1: done_ts=%b want 1", done_ts); end
    step();
    checks++;
    if (done_ts !== 1'b0) begin failures++; $display("FAIL off_lat2: done_ts=%b want 0", done_ts); end
  endtask

  task automatic test_blink();
    int  last_edge;
    logic prev;
    int  n_edges;
    mode = 2'd2;
    last_edge = -1; n_edges = 0;
    step(); step();
    prev = done_ts;
    checks++;
    if (done_ts !== 1'b0) begin failures++; $display("FAIL blink_start: done_ts=%b want 0", done_ts); end
    for (int i = 0; i < 130; i++) begin
      step();
      checks++;
      if (done_ts !== m_done) begin
        failures++;
        $display("FAIL blink cyc=%0d: done_ts=%b want %b", cyc, done_ts, m_done);
      end
      if (done_ts !== prev) begin
        n_edges++;
        if (last_edge >= 0) begin
          checks++;
          if (cyc - last_edge != BT * DIV) begin
            failures++;
            $display("FAIL blink_period: %0d clk between toggles want %0d", cyc - last_edge, BT * DIV);
          end
        end
        last_edge = cyc;
      end
      prev = done_ts;
    end
    checks++;
    if (n_edges < 3) begin failures++; $display("FAIL blink_toggles: got %0d want >=3", n_edges); end
  endtask

  task automatic test_breathe();
    int peak1, peak2, max_d;
    logic [3:0] prev_d;
    mode = 2'd3;
    peak1 = -1; peak2 = -1; max_d = 0; prev_d = 4'd0;
    for (int i = 0; i < 480; i++) begin
      step();
      checks++;
      if (done_ts !== m_done || int'(duty) != exp_duty()) begin
        failures++;
        $display("FAIL breathe cyc=%0d: done_ts=%b duty=%0d want %b %0d", cyc, done_ts, duty, m_done, exp_duty());
      end
      if (int'(duty) > max_d) max_d = int'(duty);
      if (duty == 4'd15 && prev_d != 4'd15) begin
        if (peak1 < 0) peak1 = cyc; else if (peak2 < 0) peak2 = cyc;
      end
      prev_d = duty;
    end
    checks++;
    if (max_d != 15) begin failures++; $display("FAIL breathe_max: got %0d want 15", max_d); end
    checks++;
    if (peak2 - peak1 != 300) begin
      failures++;
      $display("FAIL breathe_period: got %0d clk want 300", peak2 - peak1);
    end
  endtask

  task automatic test_duty_window();
    // While duty is 4 the LED must be lit only for pwm phases 0..3.
    int hi, n;
    hi = 0; n = 0;
    for (int i = 0; i < 400 && n < 16; i++) begin
      int d_prev;
      int p_prev;
      d_prev = exp_duty();
      p_prev = cyc % 16;
      step();
      if (d_prev == 4) begin
        n++;
        if (done_ts === 1'b1) hi++;
        checks++;
        if (done_ts !== (p_prev < 4)) begin
          failures++;
          $display("FAIL duty4 pwm=%0d: done_ts=%b want %b", p_prev, done_ts, p_prev < 4);
        end
      end
      if (d_prev == 0 && m_mode_q == 3 && int'(mode) == 3) begin
        checks++;
        if (done_ts !== 1'b0) begin failures++; $display("FAIL duty0: done_ts=%b want 0", done_ts); end
      end
    end
    checks++;
    if (n < 16) begin failures++; $display("FAIL duty4_timeout: saw %0d cycles at duty 4 want 16", n); end
  endtask

  task automatic test_mode_change();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (duty == 4'd9) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL mc_wait: duty never reached 9"); end
    mode = 2'd2;
    repeat (4) step();
    checks++;
    if (duty !== 4'd0 || done_ts !== 1'b0) begin
      failures++;
      $display("FAIL mc_blink: duty=%0d done_ts=%b want 0 0", duty, done_ts);
    end
    mode = 2'd3;
    step();
    checks++;
    if (duty !== 4'd0) begin failures++; $display("FAIL mc_restart: duty=%0d want 0", duty); end
    for (int i = 0; i < 60; i++) begin
      step();
      checks++;
      if (done_ts !== m_done || int'(duty) != exp_duty()) begin
        failures++;
        $display("FAIL mc_ramp cyc=%0d: done_ts=%b duty=%0d want %b %0d", cyc, done_ts, duty, m_done, exp_duty());
      end
    end
    checks++;
    if (duty > 4'd6) begin failures++; $display("FAIL mc_rampup: duty=%0d want <=6", duty); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      step();
      checks++;
      if (done_ts !== m_done || int'(duty) != exp_duty() || tick !== exp_tick()) begin
        failures++;
        $display("FAIL random cyc=%0d mode_q=%0d: done_ts=%b duty=%0d tick=%b want %b %0d %b",
                 cyc, m_mode_q, done_ts, duty, tick, m_done, exp_duty(), exp_tick());
      end
    end
  endtask

  task automatic test_async_reset();
    bit lit;
    mode = 2'd2;
    lit = 1'b0;
    for (int i = 0; i < 200 && !lit; i++) begin
      step();
      if (done_ts === 1'b1) lit = 1'b1;
    end
    checks++;
    if (!lit) begin failures++; $display("FAIL ar_wait: done_ts never went high in blink"); end
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if (done_ts !== 1'b0 || duty !== 4'd0 || tick !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: done_ts=%b duty=%0d tick=%b want 0 0 0", done_ts, duty, tick);
    end
    @(negedge clk);
    mode = 2'd0;
    rstN = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (done_ts !== 1'b0 || tick !== exp_tick()) begin
        failures++;
        $display("FAIL post_reset cyc=%0d: done_ts=%b tick=%b want 0 %b", cyc, done_ts, tick, exp_tick());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_off_on();
    test_blink();
    test_breathe();
    test_duty_window();
    test_mode_change();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
